fcn_weight_streamer: RTL and testbench

- Producer and controller for the `fcn` FC1/FC2 engine.
- Fetches packed FC1 weight words from a synchronous weight SRAM and drives `w_stream`/`w_valid` one beat per cycle, `NUM_PE` lanes per beat.
- Issues `start` to the engine, and acknowledges each neuron's `fc1_valid` with `fc1_next`.
- Reports completion to the CPU-side control when the engine's `done` pulses.

---
 rtl/fcn_weight_streamer.sv | 153 +++++++++++++++
 tb/tb_fcn_weight_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcn_weight_streamer.sv
// Weight streamer and sequencer for the fcn FC engine: fetches packed weight words from a
// synchronous SRAM, streams NUM_PE lanes per beat and handshakes each neuron with the engine.
module fcn_weight_streamer #(
    parameter int unsigned IN_N   = 132,
    parameter int unsigned OUT_M  = 10,
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    output logic                     busy,
    output logic                     layer_done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [NUM_PE*8-1:0]      mem_rdata,
    output logic                     start,
    output logic signed [7:0]        w_stream [NUM_PE],
    output logic                     w_valid,
    input  logic                     fc1_valid,
    output logic                     fc1_next,
    input  logic                     done,
    output logic [7:0]               neuron_idx
);
    localparam int unsigned BEATS    = (IN_N + NUM_PE - 1) / NUM_PE;
    localparam int unsigned CNT_W    = $clog2(BEATS + 1);
    localparam int unsigned LAST_VLD = IN_N - (BEATS - 1) * NUM_PE; // real lanes in final beat

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_WAIT_RES,
        S_WAIT_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0]   rd_addr, rd_addr_nxt, mem_addr_nxt;
    logic                rd_last, rd_last_nxt;
    logic                busy_nxt, layer_done_nxt, start_nxt, rd_en_nxt, fc1_next_nxt;
    logic [7:0]          neuron_nxt;
    logic signed [7:0]   lane_nxt [NUM_PE];
    logic                last_beat, last_neuron;

    assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
    assign last_neuron = (neuron_idx == 8'(OUT_M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (go)        state_nxt = S_STREAM;
            S_STREAM:    if (last_beat) state_nxt = S_DRAIN;
            S_DRAIN:                    state_nxt = S_WAIT_RES;
            S_WAIT_RES:  if (fc1_valid) state_nxt = last_neuron ? S_WAIT_DONE : S_STREAM;
            S_WAIT_DONE: if (done)      state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt       = busy;
        layer_done_nxt = 1'b0;
        start_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        fc1_next_nxt   = 1'b0;
        rd_last_nxt    = 1'b0;
        mem_addr_nxt   = mem_addr;
        rd_addr_nxt    = rd_addr;
        beat_cnt_nxt   = beat_cnt;
        neuron_nxt     = neuron_idx;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    busy_nxt     = 1'b1;
                    start_nxt    = 1'b1;
                    mem_addr_nxt = '0;
                    rd_addr_nxt  = '0;
                    beat_cnt_nxt = '0;
                    neuron_nxt   = '0;
                end
            end
            S_STREAM: begin
                rd_en_nxt    = 1'b1;
                mem_addr_nxt = rd_addr;
                rd_addr_nxt  = rd_addr + ADDR_W'(1);
                beat_cnt_nxt = beat_cnt + CNT_W'(1);
                rd_last_nxt  = last_beat;
            end
            S_WAIT_RES: begin
                if (fc1_valid) begin
                    fc1_next_nxt = 1'b1;
                    beat_cnt_nxt = '0;
                    if (!last_neuron) neuron_nxt = neuron_idx + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    layer_done_nxt = 1'b1;
                    busy_nxt       = 1'b0;
                    mem_addr_nxt   = '0;
                    rd_addr_nxt    = '0;
                    neuron_nxt     = '0;
                end
            end
            default: ;
        endcase
    end

    // Read data lands one cycle after the strobe; pad lanes past IN_N on the final beat.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            lane_nxt[p] = '0;
            if (mem_rd_en && !(rd_last && p >= LAST_VLD)) lane_nxt[p] = mem_rdata[8*p +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            layer_done <= 1'b0;
            start      <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            fc1_next   <= 1'b0;
            neuron_idx <= '0;
            w_valid    <= 1'b0;
            rd_addr    <= '0;
            beat_cnt   <= '0;
            rd_last    <= 1'b0;
            for (int unsigned p = 0; p < NUM_PE; p++) w_stream[p] <= '0;
        end else begin
            busy       <= busy_nxt;
            layer_done <= layer_done_nxt;
            start      <= start_nxt;
            mem_rd_en  <= rd_en_nxt;
            mem_addr   <= mem_addr_nxt;
            fc1_next   <= fc1_next_nxt;
            neuron_idx <= neuron_nxt;
            w_valid    <= mem_rd_en;
            rd_addr    <= rd_addr_nxt;
            beat_cnt   <= beat_cnt_nxt;
            rd_last    <= rd_last_nxt;
            for (int unsigned p = 0; p < NUM_PE; p++) w_stream[p] <= lane_nxt[p];
        end
    end

endmodule

// File: tb/tb_fcn_weight_streamer.sv
// Randomized bench for fcn_weight_streamer: SRAM model, behavioural engine and a reference
// model of the expected beat stream, addresses and per-neuron dot products.
module tb_fcn_weight_streamer;
    localparam int unsigned IN_N     = 132;
    localparam int unsigned OUT_M    = 10;
    localparam int unsigned NUM_PE   = 4;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned BEATS    = (IN_N + NUM_PE - 1) / NUM_PE;
    localparam int unsigned LW       = NUM_PE * 8;
    localparam int unsigned PAD_IN_N = 130;
    localparam int unsigned PBEATS   = (PAD_IN_N + NUM_PE - 1) / NUM_PE;

    logic clk = 1'b0, rst_n = 1'b1, go = 1'b0, fc1_valid = 1'b0, done = 1'b0;
    logic busy, layer_done, mem_rd_en, start, w_valid, fc1_next;
    logic [ADDR_W-1:0] mem_addr;
    logic [LW-1:0]     mem_rdata = '0;
    logic signed [7:0] w_stream [NUM_PE];
    logic [7:0]        neuron_idx;

    logic go_p = 1'b0, fc1_valid_p = 1'b0, done_p = 1'b0;
    logic busy_p, layer_done_p, mem_rd_en_p, start_p, w_valid_p, fc1_next_p;
    logic [ADDR_W-1:0] mem_addr_p;
    logic [LW-1:0]     mem_rdata_p = {NUM_PE{8'h7F}};
    logic signed [7:0] w_stream_p [NUM_PE];
    logic [7:0]        neuron_idx_p;

    fcn_weight_streamer #(.IN_N(IN_N), .OUT_M(OUT_M), .NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .layer_done(layer_done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .start(start),
        .w_stream(w_stream), .w_valid(w_valid), .fc1_valid(fc1_valid), .fc1_next(fc1_next),
        .done(done), .neuron_idx(neuron_idx)
    );

    fcn_weight_streamer #(.IN_N(PAD_IN_N), .OUT_M(OUT_M), .NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) u_pad (
        .clk(clk), .rst_n(rst_n), .go(go_p), .busy(busy_p), .layer_done(layer_done_p),
        .mem_rd_en(mem_rd_en_p), .mem_addr(mem_addr_p), .mem_rdata(mem_rdata_p), .start(start_p),
        .w_stream(w_stream_p), .w_valid(w_valid_p), .fc1_valid(fc1_valid_p), .fc1_next(fc1_next_p),
        .done(done_p), .neuron_idx(neuron_idx_p)
    );

    always #5 clk = ~clk;

    logic [LW-1:0]     mem [1 << ADDR_W];
    logic signed [7:0] xin [BEATS*NUM_PE];
    longint            exp_logit [OUT_M];
    logic [LW-1:0]     exp_q [$];

    // SRAM answers on the falling edge so the word is stable at the next rising edge.
    always @(negedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int errors = 0, checks = 0, cyc = 0;
    bit mon_en = 1'b0, hung = 1'b0;
    int exp_addr, max_addr, n_beats, n_next, n_done, n_start, first_rd_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [LW-1:0] pack_w();
        logic [LW-1:0] v;
        for (int p = 0; p < NUM_PE; p++) v[8*p +: 8] = w_stream[p];
        return v;
    endfunction

    function automatic logic [LW-1:0] pack_wp();
        logic [LW-1:0] v;
        for (int p = 0; p < NUM_PE; p++) v[8*p +: 8] = w_stream_p[p];
        return v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (mon_en) begin
            if (w_valid) begin
                if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
                else                   check("w_stream", pack_w(), exp_q.pop_front());
                n_beats++;
            end
            if (mem_rd_en) begin
                if (first_rd_cyc == 0) first_rd_cyc = cyc;
                check("mem_addr", mem_addr, exp_addr);
                exp_addr++;
                if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            end
            if (fc1_next)   n_next++;
            if (layer_done) n_done++;
            if (start)      n_start++;
        end
    end

    // Expected stream and dot products straight from the weight layout: input i of neuron n
    // sits in lane i%NUM_PE of word n*BEATS + i/NUM_PE; lanes beyond IN_N read as zero.
    task automatic build_expect();
        exp_q.delete();
        for (int n = 0; n < OUT_M; n++) begin
            exp_logit[n] = 0;
            for (int b = 0; b < BEATS; b++) begin
                logic [LW-1:0] w;
                w = mem[n*BEATS + b];
                for (int p = 0; p < NUM_PE; p++) if (b*NUM_PE + p >= IN_N) w[8*p +: 8] = 8'h00;
                exp_q.push_back(w);
            end
            for (int i = 0; i < IN_N; i++) begin
                logic [LW-1:0]     word;
                logic signed [7:0] wb;
                word = mem[n*BEATS + i/NUM_PE];
                wb   = word[8*(i%NUM_PE) +: 8];
                exp_logit[n] += longint'(wb) * longint'(xin[i]);
            end
        end
    endtask

    task automatic do_reset();
        go = 1'b0; done = 1'b0; fc1_valid = 1'b0; go_p = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hung  = 1'b0;
    endtask

    task automatic randomize_data();
        for (int a = 0; a < OUT_M*BEATS; a++) mem[a] = LW'($urandom);
        for (int i = 0; i < BEATS*NUM_PE; i++) xin[i] = 8'($urandom);
    endtask

    // One full layer with a behavioural engine; optional stall, stray go/done and abort.
    task automatic run_layer(input int stall_n, input int stall_len, input int go_n,
                             input int done_n, input bit go_with_done, input int abort_n);
        int k, k0, b, t, bad;
        longint acc;
        logic [ADDR_W-1:0] a0;
        if (hung) do_reset();
        build_expect();
        exp_addr = 0; max_addr = 0; n_beats = 0; n_next = 0; n_done = 0; n_start = 0;
        first_rd_cyc = 0;
        mon_en = 1'b1;
        @(negedge clk);
        go = 1'b1; done = go_with_done;
        @(posedge clk) #1;
        go = 1'b0; done = 1'b0;
        check("start", start, 1);
        check("busy_set", busy, 1);
        k = cyc; k0 = cyc;
        for (int n = 0; n < OUT_M; n++) begin
            acc = 0; b = 0; t = 0;
            while (b < BEATS) begin
                go   = (n == go_n && t == 0);
                done = (n == done_n && t == 0);
                @(posedge clk) #1;
                t++;
                if (w_valid) begin
                    if (b == 0) begin
                        check("first_beat_cyc", cyc, k + 2);
                        check("neuron_idx", neuron_idx, n);
                    end
                    for (int p = 0; p < NUM_PE; p++)
                        acc += longint'(w_stream[p]) * longint'(xin[b*NUM_PE + p]);
                    b++;
                    if (n == abort_n && b == 10) begin
                        go = 1'b0; done = 1'b0;
                        #3 rst_n = 1'b0;
                        #1;
                        check("abort_ctrl", {busy, layer_done, mem_rd_en, start, w_valid, fc1_next}, 0);
                        check("abort_addr", mem_addr, 0);
                        check("abort_lanes", pack_w(), 0);
                        check("abort_idx", neuron_idx, 0);
                        mon_en = 1'b0;
                        @(negedge clk) rst_n = 1'b1;
                        return;
                    end
                end
                if (t > BEATS + 10) begin
                    check("beat_timeout", b, BEATS);
                    go = 1'b0; done = 1'b0; mon_en = 1'b0; hung = 1'b1;
                    return;
                end
            end
            go = 1'b0; done = 1'b0;
            check("last_beat_cyc", cyc, k + BEATS + 1);
            check("fc1_acc", acc, exp_logit[n]);
            @(posedge clk) #1;
            if (n == stall_n) begin
                bad = 0; a0 = mem_addr;
                repeat (stall_len) begin
                    @(posedge clk) #1;
                    if (w_valid || fc1_next || mem_rd_en || mem_addr != a0) bad++;
                end
                check("stall_quiet", bad, 0);
            end
            @(posedge clk) #1;
            fc1_valid = 1'b1;
            @(posedge clk) #1;
            fc1_valid = 1'b0;
            check("fc1_next", fc1_next, 1);
            k = cyc;
        end
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        check("busy_wait_done", busy, 1);
        done = 1'b1;
        @(posedge clk) #1;
        done = 1'b0;
        check("layer_done", layer_done, 1);
        check("busy_clear", busy, 0);
        @(posedge clk) #1;
        check("layer_done_pulse", layer_done, 0);
        mon_en = 1'b0;
        check("n_beats", n_beats, OUT_M*BEATS);
        check("max_addr", max_addr, OUT_M*BEATS - 1);
        check("n_fc1_next", n_next, OUT_M);
        check("n_layer_done", n_done, 1);
        check("n_start", n_start, 1);
        check("first_read_cyc", first_rd_cyc, k0 + 1);
        check("idle_idx_addr", {neuron_idx, 7'(mem_addr)}, 0);
    endtask

    task automatic pad_test();
        int b, t;
        logic [LW-1:0] exp_v;
        @(negedge clk) go_p = 1'b1;
        @(posedge clk) #1;
        go_p = 1'b0;
        b = 0; t = 0;
        while (b < PBEATS && t < PBEATS + 10) begin
            @(posedge clk) #1;
            t++;
            if (w_valid_p) begin
                exp_v = (b == PBEATS - 1) ? 32'h0000_7F7F : 32'h7F7F_7F7F;
                check((b == PBEATS - 1) ? "pad_last_beat" : "pad_beat", pack_wp(), exp_v);
                b++;
            end
        end
        check("pad_beat_count", b, PBEATS);
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_ctrl", {busy, layer_done, mem_rd_en, start, w_valid, fc1_next}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_lanes", pack_w(), 0);
        check("rst_idx", neuron_idx, 0);

        for (int a = 0; a < (1 << ADDR_W); a++) begin
            logic [7:0] v;
            v = 8'(a);
            mem[a] = {NUM_PE{v}};
        end
        for (int i = 0; i < BEATS*NUM_PE; i++) xin[i] = 8'($urandom);
        run_layer(-1, 0, -1, -1, 1'b0, -1);

        pad_test();

        randomize_data();
        run_layer(2, 50, 4, 1, 1'b0, -1);

        randomize_data();
        run_layer(int'($urandom_range(0, OUT_M-1)), int'($urandom_range(1, 20)), -1, 6, 1'b1, -1);

        randomize_data();
        run_layer(-1, 0, -1, -1, 1'b0, 3);
        run_layer(-1, 0, -1, -1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
